process_scheduler: RTL
======================

Name: process_scheduler

Overview:
Round-robin context-switch controller for the LabSO processor. It holds a table of NUM_PROC process slots, each with a valid bit and a saved PC. On a switch request from the quantum counter, or on a process-end event, it saves the outgoing PC, picks the next ready slot in round-robin order and loads its PC into the CPU. It also clears the quantum counter and stalls the CPU during the switch.

Parameters:
NUM_PROC, 4, number of process slots (power of 2, >=2)
PC_WIDTH, 32, PC width in bits
ID_WIDTH, $clog2(NUM_PROC), slot index width

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 at posedge = reset)
troca_req  input  1  context-switch request from quantum counter (level, sampled in RUN)
pc_salvo  input  PC_WIDTH  PC to save for outgoing process, valid with troca_req
fim_processo  input  1  current process finished (sampled in RUN)
cria_valid  input  1  request to create a process
cria_pc  input  PC_WIDTH  start PC of new process
cria_ack  output  1  one-cycle pulse: creation accepted
cria_full  output  1  one-cycle pulse: creation rejected, table full
pc_novo  output  PC_WIDTH  PC to load into CPU, valid while pc_load=1
pc_load  output  1  one-cycle pulse: CPU loads pc_novo
quantum_clr  output  1  one-cycle pulse, coincident with pc_load
cpu_halt  output  1  CPU stalled (no process running or switch in progress)
proc_atual  output  ID_WIDTH  slot index of running or last-run process

Behaviour:
- Reset (reset==0 at posedge): all valid bits=0, saved PCs=0, state=IDLE, proc_atual=0, pc_novo=0, pc_load=0, quantum_clr=0, cria_ack=0, cria_full=0, cpu_halt=1. Reset overrides everything, in any state, mid-switch included.
- States: IDLE, RUN, SELECT, LOAD. cpu_halt=1 in IDLE, SELECT and LOAD; 0 only in RUN.
- IDLE: if any valid bit=1 -> SELECT, else stay.
- RUN, priority fim_processo > troca_req:
  - fim_processo=1: clear valid[proc_atual]; no save; -> SELECT.
  - troca_req=1: saved_pc[proc_atual]=pc_salvo; -> SELECT.
  - neither: stay.
- SELECT: rotating search starting at proc_atual+1 mod NUM_PROC and wrapping to proc_atual itself last.
  - First valid slot found: becomes next_id; -> LOAD.
  - No valid slot: -> IDLE, no pc_load.
- LOAD: pc_novo=saved_pc[next_id], pc_load=1, quantum_clr=1, proc_atual=next_id; -> RUN.
- Latency: request accepted in RUN at cycle N -> SELECT at N+1 -> pc_load/quantum_clr high for exactly cycle N+2 -> RUN at N+3.
- Creation, accepted in any state when reset=1:
  - Writes the lowest-index invalid slot: valid=1, saved_pc=cria_pc.
  - cria_ack pulses the following cycle.
  - No invalid slot: nothing is written and cria_full pulses the following cycle.
  - A slot created in the same cycle as a SELECT evaluation is not visible to that search.
  - If a slot is freed by fim_processo in the same cycle, that slot is not reusable until the next cycle.
- A single valid process re-selects itself on troca_req and reloads its saved PC.
- Index arithmetic is modulo NUM_PROC; PCs are stored unmodified (no increment here).

Decomposition:
- sched_pkg: state enum (IDLE, RUN, SELECT, LOAD), NUM_PROC/ID_WIDTH defaults, and a slot struct {valid, pc}.
- Sub-module rr_select: combinational rotating priority encoder. Inputs: valid vector, start index. Outputs: found, next_id. Reused for free-slot search with start=0 and an inverted vector.

Test Plan:
1. Reset low 2 cycles, release; create PCs 0x100, 0x200, 0x300 -> cria_ack x3 into slots 0,1,2; IDLE->SELECT->LOAD; pc_novo=0x100, proc_atual=0, pc_load one cycle.
2. In RUN slot0, troca_req=1 with pc_salvo=0x105 at cycle N -> pc_load at N+2 with pc_novo=0x200, proc_atual=1, quantum_clr coincident, cpu_halt=1 during N+1..N+2.
3. Running slot2, fim_processo=1 -> slot2 invalidated; search wraps, pc_novo=0x105, proc_atual=0. Assert fim_processo and troca_req together -> no save occurs.
4. NUM_PROC=4 with 4 valid slots, one more cria_valid -> cria_full pulse, table unchanged. Then end slot1, create 0x400 -> written to slot1.
5. Only slot0 valid, troca_req with pc_salvo=0x110 -> re-selects slot0, pc_novo=0x110. fim_processo on the last process -> IDLE, cpu_halt=1, no pc_load.
6. Drive reset low during LOAD -> next cycle: pc_load=0, state IDLE, all valid=0, proc_atual=0; a subsequent cria_valid recovers normally.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and defaults for the round-robin process scheduler.
package sched_pkg;

  localparam int NUM_PROC_DEF = 4;
  localparam int PC_WIDTH_DEF = 32;
  localparam int ID_WIDTH_DEF = $clog2(NUM_PROC_DEF);

  // Scheduler phases: waiting for work, running a process, searching for the
  // next ready slot, and handing its PC to the CPU.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SELECT = 2'd2,
    LOAD   = 2'd3
  } sched_state_e;

  // One process slot at the default PC width.
  typedef struct packed {
    logic                    valid;
    logic [PC_WIDTH_DEF-1:0] pc;
  } slot_t;

endpackage

// File: rtl/rr_select.sv
// Rotating priority encoder: returns the first set bit of valid_i found when
// walking upward from start_i and wrapping around, so start_i itself is
// examined first and start_i-1 last.
module rr_select #(
  parameter int NUM = 4,
  parameter int IDW = $clog2(NUM)
) (
  input  logic [NUM-1:0] valid_i,
  input  logic [IDW-1:0] start_i,
  output logic           found_o,
  output logic [IDW-1:0] nextId_o
);

  logic [IDW-1:0] idx;

  // Walk the slots in rotated order and keep the first hit.
  always_comb begin
    found_o  = 1'b0;
    nextId_o = '0;
    idx      = '0;
    for (int k = 0; k < NUM; k++) begin
      idx = start_i + IDW'(k);
      if (!found_o && valid_i[idx]) begin
        found_o  = 1'b1;
        nextId_o = idx;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin context-switch controller. Holds a table of process slots
// (valid bit + saved PC), saves the outgoing PC on a quantum expiry, picks
// the next ready slot in rotating order and loads its PC into the CPU while
// holding the CPU halted. Process creation is accepted in any phase.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PROC = NUM_PROC_DEF,
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int ID_WIDTH = $clog2(NUM_PROC)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                troca_req,
  input  logic [PC_WIDTH-1:0] pc_salvo,
  input  logic                fim_processo,
  input  logic                cria_valid,
  input  logic [PC_WIDTH-1:0] cria_pc,
  output logic                cria_ack,
  output logic                cria_full,
  output logic [PC_WIDTH-1:0] pc_novo,
  output logic                pc_load,
  output logic                quantum_clr,
  output logic                cpu_halt,
  output logic [ID_WIDTH-1:0] proc_atual
);

  // Slot entry sized to this instance's PC width.
  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
  } slotEntry_t;

  sched_state_e        state_q, state_d;
  slotEntry_t          slot_q [NUM_PROC];
  logic [NUM_PROC-1:0] validVec;

  logic [ID_WIDTH-1:0] procAtual_q, procAtual_d;
  logic [PC_WIDTH-1:0] pcNovo_q, pcNovo_d;
  logic                hasRun_q, hasRun_d;
  logic                criaAck_q, criaFull_q;

  logic [ID_WIDTH-1:0] selStart, selId, freeId;
  logic                selFound, freeFound;
  logic                endEn, saveEn, criaEn;

  // Flatten the valid bits so both searches can see the whole table at once.
  always_comb begin
    validVec = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      validVec[i] = slot_q[i].valid;
    end
  end

  // Until some process has run since reset there is no "previous" process to
  // rotate past, so the search starts at slot 0 instead of proc_atual+1.
  assign selStart = hasRun_q ? (procAtual_q + ID_WIDTH'(1)) : procAtual_q;

  rr_select #(
    .NUM (NUM_PROC),
    .IDW (ID_WIDTH)
  ) u_sel (
    .valid_i  (validVec),
    .start_i  (selStart),
    .found_o  (selFound),
    .nextId_o (selId)
  );

  // Lowest-index free slot: same encoder, inverted vector, fixed start at 0.
  rr_select #(
    .NUM (NUM_PROC),
    .IDW (ID_WIDTH)
  ) u_free (
    .valid_i  (~validVec),
    .start_i  ('0),
    .found_o  (freeFound),
    .nextId_o (freeId)
  );

  assign criaEn = cria_valid & freeFound;

  // Next-state logic; the new PC and slot index are captured on leaving
  // SELECT so they are already stable during the LOAD cycle.
  always_comb begin
    state_d     = state_q;
    procAtual_d = procAtual_q;
    pcNovo_d    = pcNovo_q;
    hasRun_d    = hasRun_q;
    endEn       = 1'b0;
    saveEn      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|validVec) begin
          state_d = SELECT;
        end
      end
      RUN: begin
        if (fim_processo) begin
          endEn   = 1'b1;
          state_d = SELECT;
        end else if (troca_req) begin
          saveEn  = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (selFound) begin
          state_d     = LOAD;
          procAtual_d = selId;
          pcNovo_d    = slot_q[selId].pc;
          hasRun_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler state register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      procAtual_q <= '0;
      pcNovo_q    <= '0;
      hasRun_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      procAtual_q <= procAtual_d;
      pcNovo_q    <= pcNovo_d;
      hasRun_q    <= hasRun_d;
    end
  end

  // Slot table: end/save touch the running slot, creation writes a slot that
  // was free before this edge, so the two never collide.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PROC; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      if (endEn) begin
        slot_q[procAtual_q].valid <= 1'b0;
      end
      if (saveEn) begin
        slot_q[procAtual_q].pc <= pc_salvo;
      end
      if (criaEn) begin
        slot_q[freeId].valid <= 1'b1;
        slot_q[freeId].pc    <= cria_pc;
      end
    end
  end

  // Creation handshake pulses, one cycle after the request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      criaAck_q  <= 1'b0;
      criaFull_q <= 1'b0;
    end else begin
      criaAck_q  <= criaEn;
      criaFull_q <= cria_valid & ~freeFound;
    end
  end

  assign cria_ack    = criaAck_q;
  assign cria_full   = criaFull_q;
  assign pc_novo     = pcNovo_q;
  assign pc_load     = (state_q == LOAD);
  assign quantum_clr = (state_q == LOAD);
  assign cpu_halt    = (state_q != RUN);
  assign proc_atual  = procAtual_q;

endmodule
